bus_adapter_queued: RTL

// Parametrised successor of the single-slot bus adapter. Sits between the loopback

---
 rtl/bus_adapter_queued.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/bus_adapter_queued.sv
// Generic in-order FIFO used for both adapter queues.
// Latency: a push is visible at the head one cycle later; there is no bypass.
// Backpressure: the caller qualifies push/pop; full/empty come from registered occupancy.
module bus_adapter_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_vld,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop_vld,
    output logic [W-1:0]               head_dat,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_vld) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop_vld) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push_vld, pop_vld})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage is not reset; the head is forced to zero while empty instead.
    always_ff @(posedge clk) begin
        if (push_vld) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    assign empty    = (cnt == '0);
    assign full     = (cnt == CW'(DEPTH));
    assign count    = cnt;
    assign head_dat = empty ? '0 : mem[rd_ptr];
endmodule

// Queued adapter between the loopback interceptor and the bus, with a stall timeout flag.
// Latency: one cycle through either queue (push in N, visible in N+1).
// Backpressure: send ready = !full | pop; bus_rdy_o = !recv_full from registered state only.
module bus_adapter_queued #(
    parameter int ADDR_W         = 4,
    parameter int TAG_W          = 4,
    parameter int DATA_W         = 64,
    parameter int SEND_DEPTH     = 4,
    parameter int RECV_DEPTH     = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            loopback_interface_valid,
    output logic                            interface_loopback_ready,
    input  logic [ADDR_W-1:0]               loopback_interface_addr,
    input  logic [TAG_W-1:0]                loopback_interface_tag,
    input  logic [DATA_W-1:0]               loopback_interface_data,
    output logic                            interface_loopback_valid,
    input  logic                            loopback_interface_ready,
    output logic [ADDR_W-1:0]               interface_loopback_addr,
    output logic [TAG_W-1:0]                interface_loopback_tag,
    output logic [DATA_W-1:0]               interface_loopback_data,
    output logic                            bus_val_o,
    input  logic                            bus_ack_i,
    output logic [ADDR_W-1:0]               bus_dst_o,
    output logic [TAG_W-1:0]                bus_tag_o,
    output logic [DATA_W-1:0]               bus_msg_o,
    input  logic                            bus_val_i,
    output logic                            bus_rdy_o,
    input  logic [ADDR_W-1:0]               bus_src_i,
    input  logic [TAG_W-1:0]                bus_tag_i,
    input  logic [DATA_W-1:0]               bus_msg_i,
    output logic [$clog2(SEND_DEPTH+1)-1:0] send_count_o,
    output logic [$clog2(RECV_DEPTH+1)-1:0] recv_count_o,
    output logic                            timeout_err_o,
    input  logic                            timeout_clr_i
);
    localparam int MW = ADDR_W + TAG_W + DATA_W;

    logic          send_push_vld;
    logic          send_pop_vld;
    logic          send_empty;
    logic          send_full;
    logic [MW-1:0] send_head_dat;
    logic          recv_push_vld;
    logic          recv_pop_vld;
    logic          recv_empty;
    logic          recv_full;
    logic [MW-1:0] recv_head_dat;

    assign bus_val_o                = !send_empty;
    assign send_pop_vld             = bus_val_o & bus_ack_i;
    assign interface_loopback_ready = !send_full | send_pop_vld;
    assign send_push_vld            = loopback_interface_valid & interface_loopback_ready;

    bus_adapter_fifo #(.W(MW), .DEPTH(SEND_DEPTH)) u_send_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (send_push_vld),
        .push_dat ({loopback_interface_addr, loopback_interface_tag, loopback_interface_data}),
        .pop_vld  (send_pop_vld),
        .head_dat (send_head_dat),
        .empty    (send_empty),
        .full     (send_full),
        .count    (send_count_o)
    );

    assign {bus_dst_o, bus_tag_o, bus_msg_o} = send_head_dat;

    // Receive ready depends only on stored occupancy, so the interceptor's
    // ready never reaches the bus combinationally.
    assign bus_rdy_o                = !recv_full;
    assign recv_push_vld            = bus_val_i & bus_rdy_o;
    assign interface_loopback_valid = !recv_empty;
    assign recv_pop_vld             = interface_loopback_valid & loopback_interface_ready;

    bus_adapter_fifo #(.W(MW), .DEPTH(RECV_DEPTH)) u_recv_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (recv_push_vld),
        .push_dat ({bus_src_i, bus_tag_i, bus_msg_i}),
        .pop_vld  (recv_pop_vld),
        .head_dat (recv_head_dat),
        .empty    (recv_empty),
        .full     (recv_full),
        .count    (recv_count_o)
    );

    assign {interface_loopback_addr, interface_loopback_tag, interface_loopback_data} = recv_head_dat;

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_tmo
            localparam int TW = $clog2(TIMEOUT_CYCLES+1);
            logic [TW-1:0] stall_cnt;
            logic          err_q;

            // A saturated counter keeps re-setting the flag, so a clear only
            // takes effect once the stall has ended.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    stall_cnt <= '0;
                    err_q     <= 1'b0;
                end else begin
                    if (!bus_val_o || bus_ack_i) begin
                        stall_cnt <= '0;
                    end else if (stall_cnt != TW'(TIMEOUT_CYCLES)) begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
                    if (stall_cnt == TW'(TIMEOUT_CYCLES)) begin
                        err_q <= 1'b1;
                    end else if (timeout_clr_i) begin
                        err_q <= 1'b0;
                    end
                end
            end

            assign timeout_err_o = err_q;
        end else begin : g_no_tmo
            logic unused_clr;
            assign unused_clr    = timeout_clr_i;
            assign timeout_err_o = 1'b0;
        end
    endgenerate
endmodule
